// File: rtl/cpu_pkg.sv
// Decode constants, the ID/EX control bundle and accelerator channel states
// shared by the decode pipeline and its testbench-facing top.
package cpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b10000;
  localparam logic [4:0] OP_ST   = 5'b10001;
  localparam logic [2:0] CLS_IMM = 3'b011;
  localparam logic [2:0] CLS_BR  = 3'b110;
  localparam logic [2:0] CLS_ACC = 3'b111;

  // Bit order matches ex_ctrl: {RegWrite, Branch, MemWrite, MemToReg, ALUSrc}.
  typedef struct packed {
    logic reg_write;
    logic branch;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_BUSY = 2'd1,
    ACC_IRQ  = 2'd2
  } acc_state_t;

  function automatic logic [2:0] instr_rd(input logic [15:0] instr);
    return (instr[15:13] == CLS_IMM) ? instr[7:5] : instr[4:2];
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [15:0] instr);
    ctrl_t      c;
    logic [4:0] op;
    logic [2:0] cls;
    op           = instr[15:11];
    cls          = instr[15:13];
    c.mem_write  = (op == OP_ST);
    c.mem_to_reg = (op == OP_LD);
    c.branch     = (cls == CLS_BR);
    c.alu_src    = c.mem_write | c.mem_to_reg | (cls == CLS_IMM);
    c.reg_write  = !((op == OP_NOP) || c.mem_write || c.branch || (cls == CLS_ACC));
    return c;
  endfunction

endpackage

// File: rtl/regfile_fwd.sv
// 8-entry register file with write-through and MEM/WB operand forwarding.
module regfile_fwd #(
  parameter int DATA_W = 16,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [2:0]        rs_i,
  input  logic [2:0]        rt_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o
);

  logic [7:0][DATA_W-1:0] rf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)       rf_q <= '0;
    else if (wb_we_i) rf_q[wb_rd_i] <= wb_data_i;
  end

  // The WB leg doubles as write-through, so it stays even without forwarding.
  function automatic logic [DATA_W-1:0] rd_port(input logic [2:0] a);
    if ((FWD_EN != 0) && mem_we_i && (mem_rd_i == a)) return mem_data_i;
    if (wb_we_i && (wb_rd_i == a))                    return wb_data_i;
    return rf_q[a];
  endfunction

  always_comb begin
    rs_data_o = rd_port(rs_i);
    rt_data_o = rd_port(rt_i);
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: hazard/accelerator stalls, forwarded operand reads, ID/EX
// register with valid/ready handshakes and per-channel accelerator FSMs.
module decode_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NACC   = 3,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [2:0]        ex_rd,
  output logic [10:0]       ex_index,
  output logic [4:0]        ex_ctrl,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wr_en,
  input  logic              wb_halt,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [NACC-1:0]   acc_start,
  input  logic [NACC-1:0]   acc_done,
  output logic [NACC-1:0]   acc_irq,
  input  logic [NACC-1:0]   acc_irq_ack
);

  logic [2:0]        cls, rs, rt, rd;
  logic [1:0]        ch;
  logic              is_nop, is_acc, use_rs, use_rt, wb_we;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] rs_data, rt_data;

  assign cls    = if_instr[15:13];
  assign rs     = if_instr[10:8];
  assign rt     = if_instr[7:5];
  assign ch     = if_instr[12:11];
  assign rd     = instr_rd(if_instr);
  assign ctrl   = decode_ctrl(if_instr);
  assign is_nop = (if_instr[15:11] == OP_NOP);
  assign is_acc = (cls == CLS_ACC);
  assign use_rs = !is_nop;
  assign use_rt = !is_nop && (cls != CLS_IMM);
  assign wb_we  = wb_wr_en & ~wb_halt;

  function automatic logic reads(input logic [2:0] r);
    return (use_rs && (rs == r)) || (use_rt && (rt == r));
  endfunction

  regfile_fwd #(.DATA_W(DATA_W), .FWD_EN(FWD_EN)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we_i   (wb_we),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .mem_we_i  (mem_wr_en),
    .mem_rd_i  (mem_rd),
    .mem_data_i(mem_data),
    .rs_i      (rs),
    .rt_i      (rt),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data)
  );

  logic              ex_valid_q;
  logic [15:0]       ex_instr_q;
  logic [DATA_W-1:0] ex_rs_q, ex_rt_q;
  logic [2:0]        ex_rd_q;
  ctrl_t             ex_ctrl_q;

  logic              ld_haz, dep_haz, acc_haz, stall, adv, accept;
  logic [NACC-1:0]   ch_busy;

  // A load's data only exists from MEM onward, so it always costs one bubble.
  assign ld_haz = ex_valid_q && ex_ctrl_q.mem_to_reg && reads(ex_rd_q);

  if (FWD_EN != 0) begin : g_fwd
    assign dep_haz = 1'b0;
  end else begin : g_nofwd
    assign dep_haz = (ex_valid_q && ex_ctrl_q.reg_write && reads(ex_rd_q)) ||
                     (mem_wr_en && reads(mem_rd)) ||
                     (wb_we && reads(wb_rd));
  end

  always_comb begin
    acc_haz = is_acc && (int'(ch) >= NACC);
    for (int i = 0; i < NACC; i++)
      if (is_acc && (ch == 2'(i)) && ch_busy[i]) acc_haz = 1'b1;
  end

  // Stalls only mean something when fetch actually presents an instruction.
  assign stall    = if_valid && (ld_haz || dep_haz || acc_haz);
  assign adv      = ex_ready | ~ex_valid_q;
  assign id_ready = flush | (~stall & adv);
  assign accept   = if_valid & id_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
    end else if (adv) begin
      ex_valid_q <= accept;
      ex_instr_q <= accept ? if_instr : '0;
      ex_rs_q    <= accept ? rs_data  : '0;
      ex_rt_q    <= accept ? rt_data  : '0;
      ex_rd_q    <= accept ? rd       : '0;
      ex_ctrl_q  <= accept ? ctrl     : '0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_instr   = ex_instr_q;
  assign ex_rs_data = ex_rs_q;
  assign ex_rt_data = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_index   = ex_instr_q[10:0];
  assign ex_ctrl    = ex_ctrl_q;

  for (genvar g = 0; g < NACC; g++) begin : g_acc
    acc_state_t st_q;
    logic       launch;

    assign launch = rst_n && accept && is_acc && (ch == 2'(g));

    always_ff @(posedge clk) begin
      if (!rst_n) st_q <= ACC_IDLE;
      else begin
        case (st_q)
          ACC_IDLE: if (launch)         st_q <= ACC_BUSY;
          ACC_BUSY: if (acc_done[g])    st_q <= ACC_IRQ;
          ACC_IRQ:  if (acc_irq_ack[g]) st_q <= ACC_IDLE;
          default:                      st_q <= ACC_IDLE;
        endcase
      end
    end

    assign acc_start[g] = launch;
    assign acc_irq[g]   = (st_q == ACC_IRQ);
    assign ch_busy[g]   = (st_q != ACC_IDLE);
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed and randomized checks of decode_pipe against a behavioural model.
module tb_decode_pipe;
  localparam int DW   = 16;
  localparam int NACC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, if_valid, flush, ex_ready, mem_wr_en, wb_wr_en, wb_halt;
  logic [15:0]     if_instr;
  logic [2:0]      mem_rd, wb_rd;
  logic [DW-1:0]   mem_data, wb_data;
  logic [NACC-1:0] acc_done, acc_irq_ack;

  logic            id_ready, ex_valid;
  logic [15:0]     ex_instr;
  logic [DW-1:0]   ex_rs_data, ex_rt_data;
  logic [2:0]      ex_rd;
  logic [10:0]     ex_index;
  logic [4:0]      ex_ctrl;
  logic [NACC-1:0] acc_start, acc_irq;

  logic            nf_id_ready, nf_ex_valid;
  logic [15:0]     nf_ex_instr;
  logic [DW-1:0]   nf_ex_rs_data, nf_ex_rt_data;
  logic [2:0]      nf_ex_rd;
  logic [10:0]     nf_ex_index;
  logic [4:0]      nf_ex_ctrl;
  logic [NACC-1:0] nf_acc_start, nf_acc_irq;

  decode_pipe #(.DATA_W(DW), .NACC(NACC), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_index(ex_index),
    .ex_ctrl(ex_ctrl), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_data(wb_data),
    .acc_start(acc_start), .acc_done(acc_done), .acc_irq(acc_irq), .acc_irq_ack(acc_irq_ack)
  );

  decode_pipe #(.DATA_W(DW), .NACC(NACC), .FWD_EN(0)) u_nf (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .id_ready(nf_id_ready),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(nf_ex_valid), .ex_instr(nf_ex_instr),
    .ex_rs_data(nf_ex_rs_data), .ex_rt_data(nf_ex_rt_data), .ex_rd(nf_ex_rd),
    .ex_index(nf_ex_index), .ex_ctrl(nf_ex_ctrl), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_data(mem_data), .wb_wr_en(wb_wr_en), .wb_halt(wb_halt), .wb_rd(wb_rd),
    .wb_data(wb_data), .acc_start(nf_acc_start), .acc_done(acc_done), .acc_irq(nf_acc_irq),
    .acc_irq_ack(acc_irq_ack)
  );

  // Behavioural model state
  logic [DW-1:0] m_rf [8];
  bit            m_v;
  logic [15:0]   m_instr;
  logic [DW-1:0] m_rs, m_rt;
  int            m_st [NACC];   // 0 idle, 1 busy, 2 irq pending

  int              n_chk = 0, n_err = 0;
  logic            s_rdy, s_nf_rdy;
  logic [NACC-1:0] s_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_i(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {5'b00001, rs, rt, rd, 2'b00};
  endfunction
  function automatic logic [15:0] ld_i(input logic [2:0] rd);
    return {5'b10000, 3'd0, 3'd0, rd, 2'b00};
  endfunction
  function automatic logic [15:0] acc_i(input logic [1:0] ch);
    return {3'b111, ch, 11'd0};
  endfunction

  function automatic logic [2:0] m_dest(input logic [15:0] ins);
    return (ins[15:13] == 3'b011) ? ins[7:5] : ins[4:2];
  endfunction

  function automatic bit m_reads(input logic [15:0] ins, input logic [2:0] r);
    bit nop, imm;
    nop = (ins[15:11] == 5'd0);
    imm = (ins[15:13] == 3'b011);
    return !nop && ((ins[10:8] == r) || (!imm && (ins[7:5] == r)));
  endfunction

  function automatic logic [4:0] m_ctrl(input logic [15:0] ins);
    int op, cls;
    bit ld, st, br, acc, imm;
    op  = int'(ins[15:11]);
    cls = int'(ins[15:13]);
    ld  = (op == 16);
    st  = (op == 17);
    br  = (cls == 6);
    acc = (cls == 7);
    imm = (cls == 3);
    return {!(op == 0 || st || br || acc), br, st, ld, ld || st || imm};
  endfunction

  function automatic logic [DW-1:0] m_opnd(input logic [2:0] r);
    if (mem_wr_en && mem_rd == r)             return mem_data;
    if (wb_wr_en && !wb_halt && wb_rd == r)   return wb_data;
    return m_rf[r];
  endfunction

  task automatic set_idle();
    if_valid = 0; if_instr = '0; flush = 0; ex_ready = 1;
    mem_wr_en = 0; mem_rd = '0; mem_data = '0;
    wb_wr_en = 0; wb_halt = 0; wb_rd = '0; wb_data = '0;
    acc_done = '0; acc_irq_ack = '0;
  endtask

  // One clock: check handshake outputs mid-cycle, advance the model, check registers.
  task automatic step();
    bit stall, rdy, acc_in;
    int ch;
    logic [NACC-1:0] exp_start, exp_irq;
    #2;
    ch     = int'(if_instr[12:11]);
    acc_in = (if_instr[15:13] == 3'b111);
    stall  = 0;
    if (if_valid) begin
      if (m_v && m_instr[15:11] == 5'b10000 && m_reads(if_instr, m_dest(m_instr))) stall = 1;
      if (acc_in && (ch >= NACC || m_st[ch] != 0)) stall = 1;
    end
    rdy       = flush || (!stall && (ex_ready || !m_v));
    exp_start = '0;
    if (if_valid && rdy && !flush && acc_in) exp_start[ch] = 1'b1;
    s_rdy = id_ready; s_nf_rdy = nf_id_ready; s_start = acc_start;
    chk("id_ready", id_ready, rdy);
    chk("acc_start", acc_start, exp_start);

    if (ex_ready || !m_v) begin
      m_v = if_valid && rdy && !flush;
      if (m_v) begin
        m_instr = if_instr;
        m_rs    = m_opnd(if_instr[10:8]);
        m_rt    = m_opnd(if_instr[7:5]);
      end
    end
    if (wb_wr_en && !wb_halt) m_rf[wb_rd] = wb_data;
    for (int i = 0; i < NACC; i++) begin
      case (m_st[i])
        0:       if (exp_start[i])   m_st[i] = 1;
        1:       if (acc_done[i])    m_st[i] = 2;
        default: if (acc_irq_ack[i]) m_st[i] = 0;
      endcase
    end

    @(posedge clk); #1;
    chk("ex_valid", ex_valid, m_v);
    chk("ex_ctrl", ex_ctrl, m_v ? m_ctrl(m_instr) : 5'd0);
    if (m_v) begin
      chk("ex_instr", ex_instr, m_instr);
      chk("ex_rs_data", ex_rs_data, m_rs);
      chk("ex_rt_data", ex_rt_data, m_rt);
      chk("ex_rd", ex_rd, m_dest(m_instr));
      chk("ex_index", ex_index, m_instr[10:0]);
    end
    for (int i = 0; i < NACC; i++) exp_irq[i] = (m_st[i] == 2);
    chk("acc_irq", acc_irq, exp_irq);
  endtask

  // Reset with an ACC launch presented, so a launch leaking through reset shows up.
  task automatic do_reset();
    set_idle();
    rst_n = 0; if_valid = 1; if_instr = acc_i(2'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_instr", ex_instr, 0);
    chk("rst_ex_rs", ex_rs_data, 0);
    chk("rst_acc_irq", acc_irq, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_id_ready", id_ready, 1);
    set_idle();
    rst_n = 1;
    m_v = 0; m_instr = '0; m_rs = '0; m_rt = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    for (int i = 0; i < NACC; i++) m_st[i] = 0;
  endtask

  initial begin
    logic [15:0] held;
    do_reset();

    // R1=5, R2=7, then ADD R3 = R1,R2
    wb_wr_en = 1; wb_rd = 3'd1; wb_data = 16'd5; step();
    wb_rd = 3'd2; wb_data = 16'd7; step();
    set_idle(); if_valid = 1; if_instr = alu_i(3'd3, 3'd1, 3'd2); step();
    chk("add_rs", ex_rs_data, 16'd5);
    chk("add_rt", ex_rt_data, 16'd7);
    chk("add_regwrite", ex_ctrl[4], 1);

    // Load-use: one stall cycle, one bubble, then MEM-forwarded operand
    if_instr = ld_i(3'd3); step();
    if_instr = alu_i(3'd6, 3'd3, 3'd0); step();
    chk("ld_stall", s_rdy, 0);
    chk("ld_bubble", ex_valid, 0);
    mem_wr_en = 1; mem_rd = 3'd3; mem_data = 16'h00AA; step();
    chk("ld_fwd", ex_rs_data, 16'h00AA);

    // MEM beats WB; the no-forward build stalls instead
    if_instr = alu_i(3'd1, 3'd4, 3'd0);
    mem_wr_en = 1; mem_rd = 3'd4; mem_data = 16'h1111;
    wb_wr_en = 1; wb_rd = 3'd4; wb_data = 16'h2222; step();
    chk("fwd_prio", ex_rs_data, 16'h1111);
    chk("nofwd_stall", s_nf_rdy, 0);

    // Accelerator channel 1 lifecycle with a stalled second launch
    set_idle(); if_valid = 1; if_instr = acc_i(2'd1); step();
    chk("acc_start_ch1", s_start, 3'b010);
    step();
    chk("acc_busy_stall", s_rdy, 0);
    acc_done = 3'b010; step(); acc_done = '0;
    chk("acc_irq_ch1", acc_irq, 3'b010);
    acc_irq_ack = 3'b010; step(); acc_irq_ack = '0;
    chk("acc_irq_clear", acc_irq, 3'b000);
    step();
    chk("acc_reissue", s_start, 3'b010);
    if_valid = 0; acc_done = 3'b010; step();
    acc_done = '0; acc_irq_ack = 3'b010; step();

    // Flush an ACC in decode
    set_idle(); if_valid = 1; if_instr = acc_i(2'd2); flush = 1; step();
    chk("flush_start", s_start, 0);
    chk("flush_ready", s_rdy, 1);
    chk("flush_bubble", ex_valid, 0);

    // Out-of-range channel stalls until flushed
    flush = 0; if_instr = acc_i(2'd3); step();
    chk("oor_stall0", s_rdy, 0);
    step();
    chk("oor_stall1", s_rdy, 0);
    flush = 1; step();
    chk("oor_flush", s_rdy, 1);

    // Halted WB write must not land in R5
    set_idle(); wb_wr_en = 1; wb_halt = 1; wb_rd = 3'd5; wb_data = 16'hDEAD; step();
    set_idle(); if_valid = 1; if_instr = alu_i(3'd1, 3'd5, 3'd0); step();
    chk("halt_r5", ex_rs_data, 16'h0000);

    // Backpressure holds ID/EX for three cycles
    held = alu_i(3'd1, 3'd5, 3'd0);
    ex_ready = 0; if_instr = alu_i(3'd2, 3'd1, 3'd2);
    repeat (3) begin
      step();
      chk("hold_valid", ex_valid, 1);
      chk("hold_instr", ex_instr, held);
    end
    ex_ready = 1;

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if_valid  = ($urandom_range(0, 3) != 0);
      if_instr  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) if_instr[15:11] = 5'b10000;
      flush     = ($urandom_range(0, 9) == 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      mem_wr_en = 1'($urandom);
      mem_rd    = 3'($urandom);
      mem_data  = 16'($urandom);
      wb_wr_en  = 1'($urandom);
      wb_halt   = ($urandom_range(0, 7) == 0);
      wb_rd     = 3'($urandom);
      wb_data   = 16'($urandom);
      acc_done  = NACC'($urandom);
      acc_irq_ack = NACC'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-cycle decode stage of the 16-bit CPU; sits between fetch and execute.
- Registers its outputs into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Detects RAW hazards and stalls on them; forwards MEM and WB results into the operand reads.
- Launches up to NACC crypto accelerators (hash, encrypt, decrypt, …) and tracks each one with its own busy/interrupt FSM.

Parameters:
- DATA_W, 16, register and operand width.
- NACC, 3, accelerator channel count, 1..4.
- FWD_EN, 1, 1 enables MEM/WB forwarding; 0 stalls on every pending writer instead.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  16  instruction from fetch
- id_ready  out  1  decode accepts if_instr this cycle
- flush  in  1  branch redirect: drop the instruction in decode
- ex_ready  in  1  execute can take the ID/EX register
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_instr  out  16  registered instruction
- ex_rs_data, ex_rt_data  out  DATA_W each  registered operands after forwarding
- ex_rd  out  3  destination register
- ex_index  out  11  instr[10:0]
- ex_ctrl  out  5  {RegWrite, Branch, MemWrite, MemToReg, ALUSrc}
- mem_wr_en  in  1  MEM stage will write a register
- mem_rd  in  3  MEM destination register
- mem_data  in  DATA_W  MEM result
- wb_wr_en  in  1  WB write enable
- wb_halt  in  1  WB halted; suppresses the register-file write
- wb_rd  in  3  WB destination register
- wb_data  in  DATA_W  WB data
- acc_start  out  NACC  one-cycle launch pulse per channel
- acc_done  in  NACC  completion pulse per channel
- acc_irq  out  NACC  interrupt level per channel
- acc_irq_ack  in  NACC  interrupt acknowledge per channel

Behaviour:
- Instruction fields:
  - opcode = [15:11], rs = [10:8], rt = [7:5].
  - rd = [7:5] when [15:13]==3'b011, else [4:2].
- Opcode classes:
  - NOP = 5'b00000, LD = 5'b10000, ST = 5'b10001.
  - BR class = [15:13]==3'b110.
  - ACC class = [15:13]==3'b111, channel = [12:11].
- Control outputs:
  - RegWrite = 0 for NOP, ST, BR and ACC; 1 for everything else.
  - MemWrite = ST. MemToReg = LD. Branch = BR class. ALUSrc = LD | ST | class 3'b011.
- Register file:
  - 8 x DATA_W, all registers reset to 0.
  - Write when wb_wr_en && !wb_halt.
  - A read of the register being written in the same cycle returns wb_data (write-through).
- Forwarding (FWD_EN=1), per operand, priority order:
  - mem_data when mem_wr_en and mem_rd matches.
  - else wb_data when the WB write is enabled and wb_rd matches.
  - else the register-file value.
- Hazard stall:
  - Stall when the valid ID/EX entry is an LD whose rd matches a source of the instruction in decode.
  - With FWD_EN=0, also stall when any valid ID/EX, MEM or WB writer's rd matches a source.
  - Source usage by class: rs is read by every class except NOP; rt is read by every class except NOP and class 011.
- Acc stall: stall an ACC instruction whose channel FSM is not IDLE, or whose channel >= NACC. An out-of-range channel stalls permanently; flush clears it.
- Handshake:
  - id_ready = flush | (!stall & (ex_ready | !ex_valid)).
  - accept = if_valid & id_ready & !flush.
- ID/EX register update, when ex_ready | !ex_valid:
  - on accept, load the new instruction;
  - otherwise load a bubble (ex_valid = 0; ex_ctrl is 0 when ex_valid = 0).
  - With ex_ready=0 and ex_valid=1, the register holds.
- Flush: the decode instruction is consumed and no acc_start is issued; it has priority over stall and accept.
- Per-channel FSM, states IDLE, BUSY, IRQ:
  - IDLE -> BUSY on accept of an ACC instruction to that channel; acc_start pulses that same cycle.
  - BUSY -> IRQ on acc_done. acc_irq = 1 while in IRQ.
  - IRQ -> IDLE on acc_irq_ack.
  - acc_done outside BUSY is ignored. acc_irq_ack outside IRQ is ignored.
- Reset values: every output 0, except id_ready, which follows the handshake equation above. All FSMs IDLE; ID/EX register cleared. Reset asserted mid-operation aborts it.

Decomposition:
- cpu_pkg holds:
  - opcode constants and class codes;
  - the ctrl_t packed struct for the 5 control bits;
  - the acc_state_t enum.
- Sub-module regfile_fwd: register file, write-through and forwarding muxes.
- The FSMs and the ID/EX register live in the top module.

Test Plan:
- Reset, then ADD (RegWrite=1) with rs=1, rt=2, R1=5, R2=7, ex_ready=1 -> next cycle ex_valid=1, operands 5/7, ex_ctrl RegWrite=1.
- LD rd=R3 in ID/EX, then an ALU instruction reading R3 -> id_ready=0 for one cycle, one bubble, then issue with ex_rs_data = mem_data (0x00AA).
- mem_wr_en and wb_wr_en both targeting R4 (0x1111 / 0x2222) -> ex_rs_data = 0x1111. With FWD_EN=0 -> stall instead.
- ACC to ch1 -> acc_start=3'b010 for one cycle. A second ACC to ch1 stalls. acc_done[1] -> acc_irq[1]=1. acc_irq_ack[1] -> the stalled instruction issues the following cycle.
- flush with an ACC instruction in decode -> no acc_start, id_ready=1, ex_valid=0 the next cycle.
- wb_halt=1 with wb_wr_en=1 to R5 -> R5 unchanged. ex_ready=0 for 3 cycles -> ID/EX register and ex_valid held constant.
